phy_lane_scheduler: RTL and testbench
=====================================

// Module: phy_lane_scheduler
// PURPOSE
//  Round-robin scheduler sharing one byte-wide PHY transmit slot among four input lanes.
//  Each lane has a small FIFO; one word is granted per clk_4f cycle (4 slots per clk_f period).
//  Sits between the lane sources and the PHY serializer.
//  While the link is not yet synced, granted words go to the recirculation port, not the PHY.
// PARAMETERS
//  DATA_W       8      lane / output word width
//  FIFO_DEPTH   2      words per lane FIFO; power of 2, >= 2
//  SYNC_CYCLES  4      consecutive active_in=1 cycles needed to enter ACTIVE; >= 1
//  IDLE_SYM     8'hBC  value driven on data_out whenever valid_out=0
// PORTS
//  clk_4f        in   1           single clock, all logic on posedge
//  reset_L       in   1           asynchronous active-low reset
//  data_in_0..3  in   DATA_W      lane n write data
//  valid_in_0..3 in   1           lane n write request
//  ready_out_0..3 out 1           lane n FIFO can accept (not full and reset_L=1)
//  active_in     in   1           link-synced indication from PHY receiver
//  data_out      out  DATA_W      word to PHY serializer
//  valid_out     out  1           data_out holds a granted word
//  lane_out      out  2           source lane of current data_out / recirc_out word
//  recirc_out    out  DATA_W      recirculated word while link not ACTIVE
//  valid_r       out  1           recirc_out holds a granted word
//  state_out     out  2           00=INIT 01=SYNC 10=ACTIVE
// BEHAVIOUR
//  Reset: FIFOs flushed; data_out=IDLE_SYM; valid_out=0; lane_out=0; recirc_out=0; valid_r=0.
//  Reset also sets state INIT, sync counter 0, RR pointer to lane 0. ready_out_n=0 while reset_L=0.
//  Push: edge where valid_in_n & ready_out_n writes data_in_n. ready_out_n depends only on full.
//  Full FIFO refuses a push even if the same cycle pops it (no comb path ready<-grant).
//  Arbitration (comb, from registered state): scan lanes ptr, ptr+1, ... mod 4; first non-empty wins.
//  On grant of lane n: pop lane n; ptr <= (n+1) mod 4. No grant leaves ptr unchanged.
//  Latency: word pushed at edge k is earliest on the outputs after edge k+1. Outputs registered.
//  Routing uses the state register value in the grant cycle:
//  - ACTIVE: data_out<=word, valid_out<=1, valid_r<=0, lane_out<=n.
//  - INIT/SYNC: recirc_out<=word, valid_r<=1, valid_out<=0, data_out<=IDLE_SYM, lane_out<=n.
//  No grant: valid_out<=0, valid_r<=0, data_out<=IDLE_SYM; recirc_out and lane_out hold.
//  FSM transitions:
//  - INIT -> SYNC when active_in=1 (counter <= 1).
//  - SYNC: active_in=0 -> INIT, counter<=0. active_in=1 and counter==SYNC_CYCLES-1 -> ACTIVE.
//  - SYNC otherwise: counter++.
//  - ACTIVE -> INIT when active_in=0.
//  SYNC_CYCLES=1: INIT goes directly to ACTIVE.
//  State change affects routing from the next cycle's grant; words already granted are never dropped.
//  FIFO pointers wrap mod FIFO_DEPTH; full/empty via an extra wrap bit.
//  At most one pop and one push per lane per cycle; four simultaneous pushes are all accepted if not full.
// CONFIGURATION
//  SCHED_STATS_EN defined: adds output grant_cnt [63:0], four 16-bit fields, lane n at [16n+15:16n].
//  - Each field counts grants of lane n in any state, saturates at 16'hFFFF, resets to 0.
//  SCHED_STATS_EN undefined: port and counters absent; all other behaviour identical.
// TESTING
//  1. Reset, then push 8'h11 on lane 2 only, active_in=0 -> one cycle later valid_r=1, recirc_out=8'h11, lane_out=2, valid_out=0.
//  2. active_in=1 held 4 cycles -> state_out 00->01->01->01->10; while state_out=10, lane pushes appear on data_out with valid_out=1.
//  3. ACTIVE; fill all four FIFOs (lane n = 8'hA0+n), stop pushing -> lane_out order 0,1,2,3,0,1,2,3, then valid_out=0, data_out=8'hBC.
//  4. Lane 1 pushes 3 words back-to-back with no grants possible (full) -> ready_out_1=0 after 2nd push; 3rd word not stored.
//  5. ACTIVE with traffic, drop active_in for 1 cycle -> state INIT; next grants on recirc_out/valid_r; no word lost or duplicated.
//  6. Assert reset_L=0 mid-traffic -> outputs immediately at reset values, ready_out_*=0; after release all FIFOs empty and lane 0 first.
//  (SCHED_STATS_EN) 70000 grants on lane 0 -> grant_cnt[15:0]=16'hFFFF, other fields match their counts.

Source files
------------

// File: rtl/phy_lane_scheduler_if.sv
// Bundles the four lane write ports, the link-sync input and the PHY/recirculation outputs.
// grant_cnt exists only when SCHED_STATS_EN is defined.
interface phy_lane_scheduler_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in_0;
  logic [DATA_W-1:0] data_in_1;
  logic [DATA_W-1:0] data_in_2;
  logic [DATA_W-1:0] data_in_3;
  logic              valid_in_0;
  logic              valid_in_1;
  logic              valid_in_2;
  logic              valid_in_3;
  logic              ready_out_0;
  logic              ready_out_1;
  logic              ready_out_2;
  logic              ready_out_3;
  logic              active_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [1:0]        lane_out;
  logic [DATA_W-1:0] recirc_out;
  logic              valid_r;
  logic [1:0]        state_out;
`ifdef SCHED_STATS_EN
  logic [63:0]       grant_cnt;

  modport master (
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output valid_in_0, valid_in_1, valid_in_2, valid_in_3, active_in,
    input  ready_out_0, ready_out_1, ready_out_2, ready_out_3,
    input  data_out, valid_out, lane_out, recirc_out, valid_r, state_out, grant_cnt
  );

  modport slave (
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    input  valid_in_0, valid_in_1, valid_in_2, valid_in_3, active_in,
    output ready_out_0, ready_out_1, ready_out_2, ready_out_3,
    output data_out, valid_out, lane_out, recirc_out, valid_r, state_out, grant_cnt
  );
`else
  modport master (
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output valid_in_0, valid_in_1, valid_in_2, valid_in_3, active_in,
    input  ready_out_0, ready_out_1, ready_out_2, ready_out_3,
    input  data_out, valid_out, lane_out, recirc_out, valid_r, state_out
  );

  modport slave (
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    input  valid_in_0, valid_in_1, valid_in_2, valid_in_3, active_in,
    output ready_out_0, ready_out_1, ready_out_2, ready_out_3,
    output data_out, valid_out, lane_out, recirc_out, valid_r, state_out
  );
`endif
endinterface

// File: rtl/phy_lane_scheduler.sv
// Four-lane round-robin scheduler into one byte-wide PHY slot; grants recirculate until link ACTIVE.
// Optional per-lane saturating grant counters when SCHED_STATS_EN is defined.
module phy_lane_scheduler #(
  parameter int                 DATA_W      = 8,
  parameter int                 FIFO_DEPTH  = 2,
  parameter int                 SYNC_CYCLES = 4,
  parameter logic [DATA_W-1:0]  IDLE_SYM    = 8'hBC
) (
  input  logic                  clk_4f,
  input  logic                  reset_L,
  phy_lane_scheduler_if.slave   bus
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(SYNC_CYCLES) + 1;

  typedef enum logic [1:0] {
    ST_INIT   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_ACTIVE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         ptr_q;
  logic [DATA_W-1:0]  data_out_q;
  logic               valid_out_q;
  logic [1:0]         lane_q;
  logic [DATA_W-1:0]  recirc_q;
  logic               valid_r_q;

  logic [DATA_W-1:0]  din     [4];
  logic [DATA_W-1:0]  rd_word [4];
  logic [3:0]         vin, ready, empty, full, push, pop;
  logic               grant_valid;
  logic [1:0]         grant_lane;
  logic [1:0]         scan_idx;
  logic [DATA_W-1:0]  grant_word;

  assign din[0] = bus.data_in_0;
  assign din[1] = bus.data_in_1;
  assign din[2] = bus.data_in_2;
  assign din[3] = bus.data_in_3;
  assign vin    = {bus.valid_in_3, bus.valid_in_2, bus.valid_in_1, bus.valid_in_0};

  assign bus.ready_out_0 = ready[0];
  assign bus.ready_out_1 = ready[1];
  assign bus.ready_out_2 = ready[2];
  assign bus.ready_out_3 = ready[3];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
      logic [AW:0]       wr_ptr_q, rd_ptr_q;

      assign empty[gi]   = (wr_ptr_q == rd_ptr_q);
      assign full[gi]    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                           (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      // Ready looks only at full, so a pop in the same cycle never frees a slot early.
      assign ready[gi]   = ~full[gi] & reset_L;
      assign push[gi]    = vin[gi] & ready[gi];
      assign pop[gi]     = grant_valid && (grant_lane == 2'(gi));
      assign rd_word[gi] = mem_q[rd_ptr_q[AW-1:0]];

      always_ff @(posedge clk_4f) begin
        if (push[gi]) mem_q[wr_ptr_q[AW-1:0]] <= din[gi];
      end

      always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else begin
          if (push[gi]) wr_ptr_q <= wr_ptr_q + 1'b1;
          if (pop[gi])  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  endgenerate

  // Scan from the farthest offset down so the lane closest to ptr_q is the last to win.
  always_comb begin
    grant_valid = 1'b0;
    grant_lane  = ptr_q;
    scan_idx    = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      scan_idx = ptr_q + 2'(i);
      if (!empty[scan_idx]) begin
        grant_valid = 1'b1;
        grant_lane  = scan_idx;
      end
    end
  end

  assign grant_word = rd_word[grant_lane];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (bus.active_in) begin
          if (SYNC_CYCLES == 1) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_SYNC;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_SYNC: begin
        if (!bus.active_in) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(SYNC_CYCLES - 1)) begin
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!bus.active_in) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Routing follows the state held during the grant cycle, so no granted word is dropped.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      ptr_q       <= 2'd0;
      data_out_q  <= IDLE_SYM;
      valid_out_q <= 1'b0;
      lane_q      <= 2'd0;
      recirc_q    <= '0;
      valid_r_q   <= 1'b0;
    end else if (grant_valid) begin
      ptr_q  <= grant_lane + 2'd1;
      lane_q <= grant_lane;
      if (state_q == ST_ACTIVE) begin
        data_out_q  <= grant_word;
        valid_out_q <= 1'b1;
        valid_r_q   <= 1'b0;
      end else begin
        recirc_q    <= grant_word;
        valid_r_q   <= 1'b1;
        data_out_q  <= IDLE_SYM;
        valid_out_q <= 1'b0;
      end
    end else begin
      data_out_q  <= IDLE_SYM;
      valid_out_q <= 1'b0;
      valid_r_q   <= 1'b0;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.lane_out   = lane_q;
  assign bus.recirc_out = recirc_q;
  assign bus.valid_r    = valid_r_q;
  assign bus.state_out  = state_q;

`ifdef SCHED_STATS_EN
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stats
      logic [15:0] grant_cnt_q;

      always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
          grant_cnt_q <= '0;
        end else if (pop[gi] && (grant_cnt_q != 16'hFFFF)) begin
          grant_cnt_q <= grant_cnt_q + 16'd1;
        end
      end

      assign bus.grant_cnt[16*gi +: 16] = grant_cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_phy_lane_scheduler.sv
// Directed-vector bench for phy_lane_scheduler: cycle table plus hand-written reset and
// statistics sequences.
module tb_phy_lane_scheduler;

  logic clk_4f;
  logic reset_L;

  phy_lane_scheduler_if #(.DATA_W(8)) bus ();

  phy_lane_scheduler #(
    .DATA_W      (8),
    .FIFO_DEPTH  (2),
    .SYNC_CYCLES (4),
    .IDLE_SYM    (8'hBC)
  ) dut (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  typedef struct {
    string      name;
    logic [3:0] vin;
    logic [7:0] d0, d1, d2, d3;
    logic       act;
    logic       exp_vo;
    logic [7:0] exp_do;
    logic [1:0] exp_lane;
    logic       exp_vr;
    logic [7:0] exp_rc;
    logic [1:0] exp_st;
    logic [3:0] exp_rdy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [3:0] vin,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input logic [7:0] d2, input logic [7:0] d3, input logic act,
                     input logic evo, input logic [7:0] edo, input logic [1:0] elane,
                     input logic evr, input logic [7:0] erc, input logic [1:0] est,
                     input logic [3:0] erdy);
    vec_t v;
    v.name = nm; v.vin = vin; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.act = act;
    v.exp_vo = evo; v.exp_do = edo; v.exp_lane = elane; v.exp_vr = evr;
    v.exp_rc = erc; v.exp_st = est; v.exp_rdy = erdy;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] vin, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3, input logic act);
    bus.valid_in_0 = vin[0]; bus.valid_in_1 = vin[1];
    bus.valid_in_2 = vin[2]; bus.valid_in_3 = vin[3];
    bus.data_in_0 = d0; bus.data_in_1 = d1; bus.data_in_2 = d2; bus.data_in_3 = d3;
    bus.active_in = act;
  endtask

  task automatic check_all(input string nm, input logic evo, input logic [7:0] edo,
                           input logic [1:0] elane, input logic evr, input logic [7:0] erc,
                           input logic [1:0] est, input logic [3:0] erdy);
    check({nm, ".valid_out"},  bus.valid_out,  evo);
    check({nm, ".data_out"},   bus.data_out,   edo);
    check({nm, ".lane_out"},   bus.lane_out,   elane);
    check({nm, ".valid_r"},    bus.valid_r,    evr);
    check({nm, ".recirc_out"}, bus.recirc_out, erc);
    check({nm, ".state_out"},  bus.state_out,  est);
    check({nm, ".ready"},
          {bus.ready_out_3, bus.ready_out_2, bus.ready_out_1, bus.ready_out_0}, erdy);
  endtask

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  initial begin
    // Test 1: single lane-2 word while INIT lands on the recirculation port
    add("t1_push",   4'b0100, 8'h00, 8'h00, 8'h11, 8'h00, 0, 0, 8'hBC, 2'd0, 0, 8'h00, 2'd0, 4'hF);
    add("t1_grant",  4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'hBC, 2'd2, 1, 8'h11, 2'd0, 4'hF);
    add("t1_idle",   4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'hBC, 2'd2, 0, 8'h11, 2'd0, 4'hF);
    // Test 4: lane 1 fills, third word refused even though the same cycle pops
    add("t4_push1",  4'b0011, 8'h20, 8'h31, 8'h00, 8'h00, 0, 0, 8'hBC, 2'd2, 0, 8'h11, 2'd0, 4'hF);
    add("t4_push2",  4'b0010, 8'h00, 8'h32, 8'h00, 8'h00, 0, 0, 8'hBC, 2'd0, 1, 8'h20, 2'd0, 4'hD);
    add("t4_push3",  4'b0010, 8'h00, 8'h33, 8'h00, 8'h00, 0, 0, 8'hBC, 2'd1, 1, 8'h31, 2'd0, 4'hF);
    add("t4_drain",  4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'hBC, 2'd1, 1, 8'h32, 2'd0, 4'hF);
    add("t4_idle",   4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'hBC, 2'd1, 0, 8'h32, 2'd0, 4'hF);
    // Test 2: sync sequence; word granted in SYNC recirculates, next one goes to the PHY
    add("t2_sync1",  4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'hBC, 2'd1, 0, 8'h32, 2'd1, 4'hF);
    add("t2_sync2",  4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'hBC, 2'd1, 0, 8'h32, 2'd1, 4'hF);
    add("t2_sync3",  4'b1000, 8'h00, 8'h00, 8'h00, 8'h44, 1, 0, 8'hBC, 2'd1, 0, 8'h32, 2'd1, 4'hF);
    add("t2_active", 4'b0001, 8'h55, 8'h00, 8'h00, 8'h00, 1, 0, 8'hBC, 2'd3, 1, 8'h44, 2'd2, 4'hF);
    add("t2_data",   4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h55, 2'd0, 0, 8'h44, 2'd2, 4'hF);
    // Test 3: pointer realigned to lane 0, then two full rounds of A0..A3
    add("t3_align",  4'b1000, 8'h00, 8'h00, 8'h00, 8'h66, 1, 0, 8'hBC, 2'd0, 0, 8'h44, 2'd2, 4'hF);
    add("t3_fill1",  4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, 1, 8'h66, 2'd3, 0, 8'h44, 2'd2, 4'hF);
    add("t3_fill2",  4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1, 1, 8'hA0, 2'd0, 0, 8'h44, 2'd2, 4'h1);
    add("t3_g1",     4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'hA1, 2'd1, 0, 8'h44, 2'd2, 4'h3);
    add("t3_g2",     4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'hA2, 2'd2, 0, 8'h44, 2'd2, 4'h7);
    add("t3_g3",     4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'hA3, 2'd3, 0, 8'h44, 2'd2, 4'hF);
    add("t3_g4",     4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'hA0, 2'd0, 0, 8'h44, 2'd2, 4'hF);
    add("t3_g5",     4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'hA1, 2'd1, 0, 8'h44, 2'd2, 4'hF);
    add("t3_g6",     4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'hA2, 2'd2, 0, 8'h44, 2'd2, 4'hF);
    add("t3_g7",     4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'hA3, 2'd3, 0, 8'h44, 2'd2, 4'hF);
    add("t3_idle",   4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'hBC, 2'd3, 0, 8'h44, 2'd2, 4'hF);
    // Test 5: one-cycle drop of active_in; later grants recirculate, nothing lost
    add("t5_load",   4'b0110, 8'h00, 8'h71, 8'h72, 8'h00, 1, 0, 8'hBC, 2'd3, 0, 8'h44, 2'd2, 4'hF);
    add("t5_drop",   4'b1000, 8'h00, 8'h00, 8'h00, 8'h73, 0, 1, 8'h71, 2'd1, 0, 8'h44, 2'd0, 4'hF);
    add("t5_init",   4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'hBC, 2'd2, 1, 8'h72, 2'd1, 4'hF);
    add("t5_sync",   4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'hBC, 2'd3, 1, 8'h73, 2'd1, 4'hF);
    add("t5_idle",   4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'hBC, 2'd3, 0, 8'h73, 2'd0, 4'hF);

    reset_L = 1'b0;
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    check_all("reset", 0, 8'hBC, 2'd0, 0, 8'h00, 2'd0, 4'h0);
    #3;
    reset_L = 1'b1;
    #1;
    check("reset_rel.ready",
          {bus.ready_out_3, bus.ready_out_2, bus.ready_out_1, bus.ready_out_0}, 4'hF);

    foreach (vecs[i]) begin
      drive(vecs[i].vin, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].act);
      tick();
      check_all(vecs[i].name, vecs[i].exp_vo, vecs[i].exp_do, vecs[i].exp_lane,
                vecs[i].exp_vr, vecs[i].exp_rc, vecs[i].exp_st, vecs[i].exp_rdy);
      $display("vec %0d %s applied", i, vecs[i].name);
    end

    // Test 6: asynchronous reset in the middle of traffic
    drive(4'b1111, 8'h80, 8'h81, 8'h82, 8'h83, 1'b1);
    tick();
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    tick();
    check("t6_pre.recirc_out", bus.recirc_out, 8'h80);
    tick();
    check("t6_pre2.recirc_out", bus.recirc_out, 8'h81);
    check("t6_pre2.lane_out", bus.lane_out, 2'd1);
    #3;
    reset_L = 1'b0;
    #1;
    check_all("t6_reset", 0, 8'hBC, 2'd0, 0, 8'h00, 2'd0, 4'h0);
    $display("t6 async reset applied");
    @(negedge clk_4f);
    reset_L = 1'b1;
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    check_all("t6_flushed", 0, 8'hBC, 2'd0, 0, 8'h00, 2'd0, 4'hF);
    drive(4'b1001, 8'h90, 8'h00, 8'h00, 8'h93, 1'b0);
    tick();
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    check_all("t6_first", 0, 8'hBC, 2'd0, 1, 8'h90, 2'd0, 4'hF);
    tick();
    check_all("t6_second", 0, 8'hBC, 2'd3, 1, 8'h93, 2'd0, 4'hF);
    tick();
    check_all("t6_idle", 0, 8'hBC, 2'd3, 0, 8'h93, 2'd0, 4'hF);
    $display("t6 post-reset sequence applied");

`ifdef SCHED_STATS_EN
    @(negedge clk_4f);
    reset_L = 1'b0;
    @(negedge clk_4f);
    reset_L = 1'b1;
    check("stats_reset.grant_cnt", bus.grant_cnt, 64'h0);
    drive(4'b0010, 8'h00, 8'h5A, 8'h00, 8'h00, 1'b0);
    repeat (5) tick();
    drive(4'b0001, 8'hC3, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (70000) tick();
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (4) tick();
    check("stats.lane0", bus.grant_cnt[15:0],  16'hFFFF);
    check("stats.lane1", bus.grant_cnt[31:16], 16'd5);
    check("stats.lane2", bus.grant_cnt[47:32], 16'd0);
    check("stats.lane3", bus.grant_cnt[63:48], 16'd0);
    $display("stats sequence applied");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
